branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/bp_pkg.sv | 10 +
 rtl/pred_queue.sv | 42 ++++
 rtl/branch_resolver.sv | 80 ++++++++
 tb/tb_branch_resolver.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types for the branch resolver and its prediction queue.
package bp_pkg;
  localparam int PC_W = 32;
  typedef enum logic {RUN, FLUSH} state_t;
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_pc;
  } entry_t;
endpackage

// File: rtl/pred_queue.sv
// pred_queue: FIFO of in-flight predictions with clear and wrap-around pointers.
module pred_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  entry_t din,
  output entry_t head,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  assign head = mem[rp];
  assign full = cnt == (PW+1)'(DEPTH);
  assign empty = cnt == '0;
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wp] <= din;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (clear) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: checks predictions at execute, raises flushes and trains the predictor.
module branch_resolver
  import bp_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int TARGET_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    f_valid,
  input  logic [PC_W-1:0]         f_pc,
  input  logic                    f_pred_taken,
  input  logic [PC_W-1:0]         f_pred_pc,
  output logic                    f_stall,
  input  logic                    ex_valid,
  input  logic [PC_W-1:0]         ex_pc,
  input  logic                    ex_branch,
  input  logic                    branch_taken,
  input  logic [TARGET_WIDTH-1:0] ex_imm,
  output logic                    ex_flush,
  output logic [PC_W-1:0]         redirect_pc,
  output logic                    upd_valid,
  output logic [PC_W-1:0]         upd_pc,
  output logic                    upd_taken,
  output logic [TARGET_WIDTH-1:0] upd_imm,
  output logic [15:0]             br_count,
  output logic [15:0]             mis_count,
  output logic                    q_err
);
  state_t state;
  entry_t head, hd;
  logic full, empty, res, pop, push, pc_bad, mis, upd;
  logic [PC_W-1:0] actual;
  assign res = ex_valid && state == RUN;
  assign pop = res && !empty;
  assign push = f_valid && state == RUN && (!full || pop);
  assign f_stall = full;
  // An empty queue resolves against a synthetic not-taken fall-through entry
  assign hd = empty ? {ex_pc, 1'b0, ex_pc + 32'd4} : head;
  assign actual = ex_pc + ((ex_branch && branch_taken) ? PC_W'($signed(ex_imm)) : 32'd4);
  assign pc_bad = hd.pc != ex_pc;
  assign mis = res && (hd.pred_pc != actual || pc_bad || (hd.pred_taken && 1'b0));
  assign upd = res && ex_branch;
  pred_queue #(.DEPTH(QDEPTH)) u_q (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .clear(state == FLUSH),
    .din({f_pc, f_pred_taken, f_pred_pc}),
    .head(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      ex_flush <= 1'b0;
      redirect_pc <= '0;
      upd_valid <= 1'b0;
      upd_pc <= '0;
      upd_taken <= 1'b0;
      upd_imm <= '0;
      br_count <= '0;
      mis_count <= '0;
      q_err <= 1'b0;
    end else begin
      state <= mis ? FLUSH : RUN;
      ex_flush <= mis;
      redirect_pc <= mis ? actual : '0;
      upd_valid <= upd;
      upd_pc <= upd ? ex_pc : '0;
      upd_taken <= upd && branch_taken;
      upd_imm <= upd ? ex_imm : '0;
      br_count <= br_count + 16'(upd && br_count != 16'hFFFF);
      mis_count <= mis_count + 16'(mis && mis_count != 16'hFFFF);
      q_err <= q_err | (res && (empty || pc_bad));
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed and random checks against a queue-based model.
module tb_branch_resolver;
  localparam int QD = 4;
  localparam int TW = 12;
  logic clk = 0, rst = 1;
  logic f_valid = 0, f_pred_taken = 0, ex_valid = 0, ex_branch = 0, branch_taken = 0;
  logic [31:0] f_pc = 0, f_pred_pc = 0, ex_pc = 0;
  logic [TW-1:0] ex_imm = 0;
  logic f_stall, ex_flush, upd_valid, upd_taken, q_err;
  logic [31:0] redirect_pc, upd_pc;
  logic [TW-1:0] upd_imm;
  logic [15:0] br_count, mis_count;
  branch_resolver #(.QDEPTH(QD), .TARGET_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
    .f_pred_pc(f_pred_pc), .f_stall(f_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_branch(ex_branch), .branch_taken(branch_taken), .ex_imm(ex_imm), .ex_flush(ex_flush),
    .redirect_pc(redirect_pc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_imm(upd_imm), .br_count(br_count), .mis_count(mis_count), .q_err(q_err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] pc; logic pt; logic [31:0] ppc;} ent_t;
  ent_t q[$];
  int checks = 0, failures = 0;
  bit flushing, e_flush, e_upd, e_ut, e_qerr;
  logic [31:0] e_redir, e_upc;
  logic [TW-1:0] e_ui;
  int e_br, e_mc;
  function automatic logic [31:0] sx(input logic [TW-1:0] v);
    return {{(32-TW){v[TW-1]}}, v};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic reset_model();
    q.delete();
    flushing = 0; e_flush = 0; e_upd = 0; e_ut = 0; e_qerr = 0;
    e_redir = 0; e_upc = 0; e_ui = 0; e_br = 0; e_mc = 0;
  endtask
  task automatic model_step();
    ent_t h;
    bit under, bad, m, do_push;
    logic [31:0] act;
    if (flushing) begin
      q.delete();
      flushing = 0; e_flush = 0; e_redir = 0; e_upd = 0; e_upc = 0; e_ut = 0; e_ui = 0;
      return;
    end
    under = q.size() == 0;
    if (under) begin
      h.pc = ex_pc; h.pt = 0; h.ppc = ex_pc + 4;
    end else h = q[0];
    act = (ex_branch && branch_taken) ? ex_pc + sx(ex_imm) : ex_pc + 4;
    bad = h.pc != ex_pc;
    m = ex_valid && (h.ppc != act || bad);
    do_push = f_valid && (q.size() < QD || (ex_valid && !under));
    if (ex_valid && !under) void'(q.pop_front());
    if (do_push) q.push_back('{f_pc, f_pred_taken, f_pred_pc});
    e_qerr = e_qerr | (ex_valid && (under || bad));
    e_flush = m; e_redir = m ? act : 0; flushing = m;
    e_upd = ex_valid && ex_branch;
    e_upc = e_upd ? ex_pc : 0;
    e_ut = e_upd && branch_taken;
    e_ui = e_upd ? ex_imm : 0;
    if (e_upd && e_br != 16'hFFFF) e_br++;
    if (m && e_mc != 16'hFFFF) e_mc++;
  endtask
  always @(posedge clk) begin
    if (rst) reset_model();
    else model_step();
  end
  always @(negedge clk) begin
    chk("f_stall", 32'(f_stall), 32'(q.size() == QD));
    chk("ex_flush", 32'(ex_flush), 32'(e_flush));
    chk("redirect_pc", redirect_pc, e_redir);
    chk("upd_valid", 32'(upd_valid), 32'(e_upd));
    chk("upd_pc", upd_pc, e_upc);
    chk("upd_taken", 32'(upd_taken), 32'(e_ut));
    chk("upd_imm", 32'(upd_imm), 32'(e_ui));
    chk("br_count", 32'(br_count), 32'(e_br));
    chk("mis_count", 32'(mis_count), 32'(e_mc));
    chk("q_err", 32'(q_err), 32'(e_qerr));
  end
  task automatic cyc(input bit fv, input logic [31:0] fpc, input bit fpt, input logic [31:0] fppc,
                     input bit exv, input logic [31:0] epc, input bit eb, input bit tk,
                     input logic [TW-1:0] imm);
    f_valid = fv; f_pc = fpc; f_pred_taken = fpt; f_pred_pc = fppc;
    ex_valid = exv; ex_pc = epc; ex_branch = eb; branch_taken = tk; ex_imm = imm;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic push(input logic [31:0] pc, input bit pt, input logic [31:0] ppc);
    cyc(1, pc, pt, ppc, 0, 0, 0, 0, 0);
  endtask
  task automatic resolve(input logic [31:0] pc, input bit b, input bit tk, input logic [TW-1:0] imm);
    cyc(0, 0, 0, 0, 1, pc, b, tk, imm);
  endtask
  task automatic rnd_cycle();
    bit fv, fpt, exv, eb, tk;
    logic [31:0] fpc, epc, off;
    logic [TW-1:0] imm;
    fv = $urandom_range(0, 1);
    fpc = {$urandom_range(0, 255), 2'b00};
    fpt = $urandom_range(0, 1);
    imm = TW'($urandom) & ~TW'(3);
    exv = $urandom_range(0, 2) != 0;
    epc = {$urandom_range(0, 255), 2'b00};
    eb = $urandom_range(0, 1);
    tk = $urandom_range(0, 1);
    if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
      epc = q[0].pc;
      off = q[0].ppc - q[0].pc;
      if ($urandom_range(0, 3) != 0) begin
        eb = q[0].pt ? 1'b1 : eb;
        tk = q[0].pt;
        imm = q[0].pt ? off[TW-1:0] : imm;
      end
    end
    cyc(fv, fpc, fpt, fpt ? fpc + sx(TW'($urandom) & ~TW'(3)) : fpc + 4, exv, epc, eb, tk, imm);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    idle(1);
    push(32'h100, 1, 32'h140);
    resolve(32'h100, 1, 1, 12'h040);
    chk("t038_flush", 32'(ex_flush), 0);
    chk("t038_upd_valid", 32'(upd_valid), 1);
    chk("t038_upd_pc", upd_pc, 32'h100);
    chk("t038_upd_taken", 32'(upd_taken), 1);
    chk("t038_br_count", 32'(br_count), 1);
    idle(1);
    push(32'h200, 0, 32'h204);
    resolve(32'h200, 1, 1, 12'h020);
    chk("t039_flush", 32'(ex_flush), 1);
    chk("t039_redirect", redirect_pc, 32'h220);
    chk("t039_mis_count", 32'(mis_count), 1);
    idle(1);
    chk("t039_flush_over", 32'(ex_flush), 0);
    for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 0, 32'h404 + 32'(4 * i));
    chk("t040_stall", 32'(f_stall), 1);
    push(32'h500, 0, 32'h504);
    cyc(1, 32'h600, 0, 32'h604, 1, 32'h400, 0, 0, 0);
    chk("t040_stall_pushpop", 32'(f_stall), 1);
    resolve(32'h404, 0, 0, 0);
    resolve(32'h408, 0, 0, 0);
    resolve(32'h40c, 0, 0, 0);
    resolve(32'h600, 0, 0, 0);
    chk("t040_drain_mis", 32'(mis_count), 1);
    chk("t040_drain_stall", 32'(f_stall), 0);
    for (int i = 0; i < 3; i++) push(32'h700 + 32'(4 * i), 0, 32'h704 + 32'(4 * i));
    resolve(32'h700, 1, 1, 12'h010);
    chk("t042_redirect", redirect_pc, 32'h710);
    push(32'h800, 0, 32'h804);
    push(32'h900, 0, 32'h904);
    resolve(32'h900, 0, 0, 0);
    chk("t042_mis_count", 32'(mis_count), 2);
    chk("t042_q_err", 32'(q_err), 0);
    push(32'hA00, 0, 32'hA04);
    resolve(32'hA00, 1, 1, 12'h008);
    chk("t043_flush", 32'(ex_flush), 1);
    #2 rst = 1;
    reset_model();
    #1;
    chk("t043_rst_flush", 32'(ex_flush), 0);
    chk("t043_rst_redirect", redirect_pc, 0);
    chk("t043_rst_counts", {br_count, mis_count}, 0);
    chk("t043_rst_upd", 32'(upd_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    idle(2);
    resolve(32'h300, 0, 0, 0);
    chk("t041_q_err", 32'(q_err), 1);
    chk("t041_flush", 32'(ex_flush), 0);
    idle(1);
    repeat (3000) rnd_cycle();
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
